// File: rtl/battleship_pkg.sv
// Shared encodings for the battleship attack sequencer and the board drawer:
// FSM states, per-cell tally codes, winner codes and the board geometry.
package battleship_pkg;

    localparam int GRID_DEF = 10;
    localparam int ROW_W    = GRID_DEF;
    localparam int TALLY_W  = 2 * GRID_DEF;

    typedef enum logic [3:0] {
        ST_START,
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_EVAL,
        ST_WR,
        ST_DRAW,
        ST_TURN,
        ST_OVER
    } state_e;

    localparam logic [1:0] TALLY_UNKNOWN = 2'b00;
    localparam logic [1:0] TALLY_MISS    = 2'b01;
    localparam logic [1:0] TALLY_HIT     = 2'b10;

    localparam logic [1:0] WON_NONE = 2'b00;
    localparam logic [1:0] WON_P1   = 2'b01;
    localparam logic [1:0] WON_P2   = 2'b10;

    // Hit counters stick at 15 rather than wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/attack_sequencer_if.sv
// Attack handshake, ship/tally RAM ports and cell-drawer request bundled together.
// master = the sequencer, slave = keyboard/RAM/drawer side.
interface attack_sequencer_if;
    import battleship_pkg::*;

    logic               atk_valid;
    logic               atk_ready;
    logic [3:0]         atk_x;
    logic [3:0]         atk_y;
    logic               atk_reject;

    logic [3:0]         ship_addr;
    logic [ROW_W-1:0]   ship_row1;
    logic [ROW_W-1:0]   ship_row2;

    logic [3:0]         tally_addr;
    logic [TALLY_W-1:0] tally_rdata1;
    logic [TALLY_W-1:0] tally_rdata2;
    logic [TALLY_W-1:0] tally_wdata;
    logic               tally_we1;
    logic               tally_we2;

    logic               draw_req;
    logic               draw_done;
    logic [3:0]         draw_x;
    logic [3:0]         draw_y;
    logic               draw_player;
    logic               draw_hit;

    modport master (
        input  atk_valid, atk_x, atk_y,
        input  ship_row1, ship_row2, tally_rdata1, tally_rdata2,
        input  draw_done,
        output atk_ready, atk_reject,
        output ship_addr, tally_addr, tally_wdata, tally_we1, tally_we2,
        output draw_req, draw_x, draw_y, draw_player, draw_hit
    );

    modport slave (
        output atk_valid, atk_x, atk_y,
        output ship_row1, ship_row2, tally_rdata1, tally_rdata2,
        output draw_done,
        input  atk_ready, atk_reject,
        input  ship_addr, tally_addr, tally_wdata, tally_we1, tally_we2,
        input  draw_req, draw_x, draw_y, draw_player, draw_hit
    );

endinterface

// File: rtl/tally_field_insert.sv
// Replaces the 2-bit tally field of column x in a row (column 0 in the MSBs)
// and returns the field it overwrote. Purely combinational.
module tally_field_insert
    import battleship_pkg::*;
#(
    parameter int GRID = GRID_DEF
) (
    input  logic [2*GRID-1:0] row,
    input  logic [3:0]        x,
    input  logic [1:0]        code,
    output logic [2*GRID-1:0] new_row,
    output logic [1:0]        old_field
);

    always_comb begin
        new_row   = row;
        old_field = TALLY_UNKNOWN;
        for (int i = 0; i < GRID; i++) begin
            if (int'(x) == i) begin
                old_field                    = row[2*(GRID-1-i) +: 2];
                new_row[2*(GRID-1-i) +: 2]   = code;
            end
        end
    end

endmodule

// File: rtl/attack_sequencer.sv
// One attack per turn: latch coordinate, read the attacker's ship/tally rows,
// reject repeats, write HIT/MISS back, request a cell redraw, then score and pass turn.
module attack_sequencer
    import battleship_pkg::*;
#(
    parameter int GRID        = GRID_DEF,
    parameter int HITS_TO_WIN = 5,
    parameter int HIT_REPEAT  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    attack_sequencer_if.master bus,
    output logic               turn,
    output logic [3:0]         hits1,
    output logic [3:0]         hits2,
    output logic [1:0]         who_won,
    output logic               display_on
);

    state_e               state_q, state_d;
    logic [3:0]           x_q, x_d;
    logic [3:0]           y_q, y_d;
    logic                 hit_q, hit_d;
    logic [TALLY_W-1:0]   wdata_q, wdata_d;
    logic                 reject_q, reject_d;
    logic                 turn_q, turn_d;
    logic [3:0]           hits1_q, hits1_d;
    logic [3:0]           hits2_q, hits2_d;
    logic [1:0]           won_q, won_d;

    logic [ROW_W-1:0]     sel_ship;
    logic [TALLY_W-1:0]   sel_tally;
    logic                 ship_bit;
    logic [TALLY_W-1:0]   ins_row;
    logic [1:0]           old_field;
    logic [3:0]           cnt_new;
    logic                 addr_en;

    // The attacker's own RAM pair holds the board being fired at.
    assign sel_ship  = turn_q ? bus.ship_row2    : bus.ship_row1;
    assign sel_tally = turn_q ? bus.tally_rdata2 : bus.tally_rdata1;

    always_comb begin
        ship_bit = 1'b0;
        for (int i = 0; i < GRID_DEF; i++) begin
            if (int'(x_q) == i) ship_bit = sel_ship[GRID_DEF-1-i];
        end
    end

    tally_field_insert #(.GRID(GRID_DEF)) u_insert (
        .row       (sel_tally),
        .x         (x_q),
        .code      (ship_bit ? TALLY_HIT : TALLY_MISS),
        .new_row   (ins_row),
        .old_field (old_field)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        hit_d    = hit_q;
        wdata_d  = wdata_q;
        reject_d = 1'b0;
        turn_d   = turn_q;
        hits1_d  = hits1_q;
        hits2_d  = hits2_q;
        won_d    = won_q;
        cnt_new  = sat_inc(turn_q ? hits2_q : hits1_q);

        unique case (state_q)
            ST_START: if (start) state_d = ST_IDLE;
            ST_IDLE: begin
                if (bus.atk_valid) begin
                    x_d = bus.atk_x;
                    y_d = bus.atk_y;
                    if (int'(bus.atk_x) >= GRID || int'(bus.atk_y) >= GRID)
                        reject_d = 1'b1;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_EVAL;
            ST_EVAL: begin
                if (old_field != TALLY_UNKNOWN) begin
                    reject_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    hit_d   = ship_bit;
                    wdata_d = ins_row;
                    state_d = ST_WR;
                end
            end
            ST_WR:   state_d = ST_DRAW;
            ST_DRAW: if (bus.draw_done) state_d = ST_TURN;
            ST_TURN: begin
                state_d = ST_IDLE;
                if (hit_q) begin
                    if (turn_q) hits2_d = cnt_new;
                    else        hits1_d = cnt_new;
                end
                if (hit_q && int'(cnt_new) == HITS_TO_WIN) begin
                    won_d   = turn_q ? WON_P2 : WON_P1;
                    state_d = ST_OVER;
                end else if (!(hit_q && HIT_REPEAT != 0)) begin
                    turn_d = ~turn_q;
                end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_START;
            x_q      <= '0;
            y_q      <= '0;
            hit_q    <= 1'b0;
            wdata_q  <= '0;
            reject_q <= 1'b0;
            turn_q   <= 1'b0;
            hits1_q  <= '0;
            hits2_q  <= '0;
            won_q    <= WON_NONE;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hit_q    <= hit_d;
            wdata_q  <= wdata_d;
            reject_q <= reject_d;
            turn_q   <= turn_d;
            hits1_q  <= hits1_d;
            hits2_q  <= hits2_d;
            won_q    <= won_d;
        end
    end

    // Row address held from the read through the write so the write lands on row y.
    assign addr_en = (state_q == ST_RD)   || (state_q == ST_WAIT) ||
                     (state_q == ST_EVAL) || (state_q == ST_WR);

    assign bus.atk_ready   = (state_q == ST_IDLE);
    assign bus.atk_reject  = reject_q;
    assign bus.ship_addr   = addr_en ? y_q : 4'd0;
    assign bus.tally_addr  = addr_en ? y_q : 4'd0;
    assign bus.tally_wdata = wdata_q;
    assign bus.tally_we1   = (state_q == ST_WR) && !turn_q;
    assign bus.tally_we2   = (state_q == ST_WR) &&  turn_q;
    assign bus.draw_req    = (state_q == ST_DRAW);
    assign bus.draw_x      = x_q;
    assign bus.draw_y      = y_q;
    assign bus.draw_player = turn_q;
    assign bus.draw_hit    = hit_q;

    assign turn       = turn_q;
    assign hits1      = hits1_q;
    assign hits2      = hits2_q;
    assign who_won    = won_q;
    assign display_on = (state_q == ST_IDLE) || (state_q == ST_RD)   ||
                        (state_q == ST_WAIT) || (state_q == ST_EVAL) ||
                        (state_q == ST_WR)   || (state_q == ST_DRAW) ||
                        (state_q == ST_TURN);

endmodule

// File: tb/tb_attack_sequencer.sv
// Drives whole games against a board-level model (cells, tallies, scores) and
// checks every handshake, write, redraw and score update of attack_sequencer.
module tb_attack_sequencer;

    localparam int G    = 10;
    localparam int HITS = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       turn;
    logic [3:0] hits1, hits2;
    logic [1:0] who_won;
    logic       display_on;

    attack_sequencer_if bus ();

    attack_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .turn       (turn),
        .hits1      (hits1),
        .hits2      (hits2),
        .who_won    (who_won),
        .display_on (display_on)
    );

    always #5 clk = ~clk;

    // Environment: synchronous-read RAMs, one per player.
    logic [9:0]  sram [2][16];
    logic [19:0] tram [2][16];
    logic        env_clear = 1'b0;

    always @(posedge clk) begin
        if (env_clear) begin
            for (int p = 0; p < 2; p++)
                for (int r = 0; r < 16; r++) tram[p][r] <= '0;
        end else begin
            if (bus.tally_we1) tram[0][bus.tally_addr] <= bus.tally_wdata;
            if (bus.tally_we2) tram[1][bus.tally_addr] <= bus.tally_wdata;
        end
        bus.ship_row1    <= sram[0][bus.ship_addr];
        bus.ship_row2    <= sram[1][bus.ship_addr];
        bus.tally_rdata1 <= tram[0][bus.tally_addr];
        bus.tally_rdata2 <= tram[1][bus.tally_addr];
    end

    // Game model: cell contents, tallies (0 unknown, 1 miss, 2 hit), scores.
    bit m_ship  [2][G][G];
    int m_tally [2][G][G];
    int m_turn, m_won;
    int m_hits [2];
    bit m_over;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] exp_row(input int p, input int y);
        logic [19:0] r;
        r = '0;
        for (int c = 0; c < G; c++) r[19-2*c -: 2] = 2'(m_tally[p][y][c]);
        return r;
    endfunction

    task automatic load_sram();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 16; r++) begin
                logic [9:0] v;
                v = '0;
                if (r < G)
                    for (int c = 0; c < G; c++) v[9-c] = m_ship[p][r][c];
                sram[p][r] = v;
            end
    endtask

    task automatic setup_game(input int density);
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < G; r++)
                for (int c = 0; c < G; c++) begin
                    m_ship[p][r][c]  = ($urandom_range(0, 99) < density);
                    m_tally[p][r][c] = 0;
                end
        m_turn = 0; m_won = 0; m_over = 0;
        m_hits[0] = 0; m_hits[1] = 0;
        load_sram();
        env_clear = 1'b1;
        tick();
        env_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.atk_valid = 1'b0;
        bus.draw_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b1;
    endtask

    task automatic final_chk(input string tag);
        chk({tag, ".turn"},    turn,    m_turn);
        chk({tag, ".hits1"},   hits1,   m_hits[0]);
        chk({tag, ".hits2"},   hits2,   m_hits[1]);
        chk({tag, ".who_won"}, who_won, m_won);
        chk({tag, ".disp"},    display_on, !m_over);
        chk({tag, ".ready"},   bus.atk_ready, !m_over);
    endtask

    task automatic attack(input int x, input int y, input int dly);
        int p, wr_at, rej_at, nwe, addr_bad;
        bit oor, rep, hit;
        p = m_turn; wr_at = -1; rej_at = -1; nwe = 0; addr_bad = 0;
        for (int i = 0; i < 20 && !bus.atk_ready; i++) tick();
        chk("atk.ready_wait", bus.atk_ready, 1);
        bus.atk_valid = 1'b1;
        bus.atk_x = 4'(x);
        bus.atk_y = 4'(y);
        tick();
        bus.atk_valid = 1'b0;

        oor = (x >= G) || (y >= G);
        rep = !oor && (m_tally[p][y][x] != 0);
        hit = !oor && m_ship[p][y][x];
        if (!oor && !rep) m_tally[p][y][x] = hit ? 2 : 1;

        for (int i = 0; i < 6; i++) begin
            if (bus.tally_we1 || bus.tally_we2) begin
                nwe++;
                wr_at = i;
                chk("atk.we_sel", {bus.tally_we1, bus.tally_we2}, (p == 0) ? 2'b10 : 2'b01);
                chk("atk.wdata",  bus.tally_wdata, exp_row(p, y));
                chk("atk.waddr",  bus.tally_addr, y);
            end
            if (bus.atk_reject && rej_at < 0) rej_at = i;
            if (oor && bus.ship_addr == 4'(y)) addr_bad++;
            if (bus.draw_req) break;
            tick();
        end

        if (oor || rep) begin
            chk("rej.at",    rej_at, oor ? 0 : 3);
            chk("rej.nwe",   nwe, 0);
            chk("rej.draw",  bus.draw_req, 0);
            if (oor && y != 0) chk("rej.addr", addr_bad, 0);
        end else begin
            chk("atk.wr_at",  wr_at, 3);
            chk("atk.nwe",    nwe, 1);
            chk("atk.no_rej", rej_at, -1);
            chk("drw.req",    bus.draw_req, 1);
            chk("drw.fields", {bus.draw_x, bus.draw_y, bus.draw_player, bus.draw_hit},
                {4'(x), 4'(y), 1'(p), hit});
            for (int d = 0; d < dly; d++) tick();
            chk("drw.hold", {bus.draw_req, bus.draw_x, bus.draw_y}, {1'b1, 4'(x), 4'(y)});
            bus.draw_done = 1'b1;
            tick();
            bus.draw_done = 1'b0;
            chk("drw.drop", bus.draw_req, 0);
            tick();
            if (hit) begin
                m_hits[p] = (m_hits[p] == 15) ? 15 : m_hits[p] + 1;
                if (m_hits[p] == HITS) begin
                    m_won = p + 1;
                    m_over = 1;
                end
            end
            if (!m_over) m_turn = 1 - m_turn;
        end
        final_chk("atk");
    endtask

    task automatic over_ignore();
        int seen;
        seen = 0;
        bus.atk_valid = 1'b1;
        bus.atk_x = 4'd1;
        bus.atk_y = 4'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.atk_ready || bus.atk_reject || bus.tally_we1 || bus.tally_we2 || bus.draw_req)
                seen++;
        end
        bus.atk_valid = 1'b0;
        chk("over.ignored", seen, 0);
        final_chk("over");
    endtask

    initial begin
        bus.atk_x = '0;
        bus.atk_y = '0;
        bus.atk_valid = 1'b0;
        bus.draw_done = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        #3;
        chk("rst.outs", {bus.atk_ready, bus.atk_reject, bus.tally_we1, bus.tally_we2,
                         bus.draw_req, display_on, turn}, 7'd0);
        chk("rst.cnt",  {hits1, hits2, who_won}, 10'd0);
        chk("rst.bus",  {bus.ship_addr, bus.tally_addr, bus.tally_wdata}, 28'd0);
        do_reset();

        // Directed opening: P1 hits (3,2), P2 misses (0,0), P1 repeats, out-of-range.
        setup_game(30);
        m_ship[0][2][3] = 1'b1;
        m_ship[1][0][0] = 1'b0;
        load_sram();
        attack(3, 2, 2);
        chk("t1.tally", tram[0][2][13:12], 2'b10);
        attack(0, 0, 0);
        chk("t2.tally", tram[1][0][19:18], 2'b01);
        attack(3, 2, 0);
        attack(10, 4, 0);
        attack(2, 12, 0);

        // A stray draw_done while idle must not disturb anything.
        bus.draw_done = 1'b1;
        tick();
        bus.draw_done = 1'b0;
        tick();
        final_chk("stray_done");

        // Random play until somebody wins.
        for (int n = 0; n < 400 && !m_over; n++)
            attack($urandom_range(0, 11), $urandom_range(0, 10), $urandom_range(0, 3));
        chk("rand.over", m_over, 1);
        over_ignore();

        // Reset while the drawer is still busy.
        do_reset();
        setup_game(0);
        m_ship[0][5][5] = 1'b1;
        load_sram();
        for (int i = 0; i < 20 && !bus.atk_ready; i++) tick();
        bus.atk_valid = 1'b1;
        bus.atk_x = 4'd5;
        bus.atk_y = 4'd5;
        tick();
        bus.atk_valid = 1'b0;
        for (int i = 0; i < 8 && !bus.draw_req; i++) tick();
        chk("t6.in_draw", bus.draw_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6.rst_outs", {bus.draw_req, bus.tally_we1, bus.tally_we2, bus.atk_ready, display_on},
            5'd0);
        chk("t6.rst_cnt", {hits1, hits2, who_won, turn}, 11'd0);
        tick();
        chk("t6.no_write", {bus.tally_we1, bus.tally_we2}, 2'b00);

        // P1 wins with five hits while P2 keeps missing.
        do_reset();
        setup_game(0);
        for (int c = 0; c < 5; c++) m_ship[0][0][c] = 1'b1;
        load_sram();
        for (int c = 0; c < 5; c++) begin
            attack(c, 0, c % 3);
            if (!m_over) attack(c, 1, 1);
        end
        chk("t5.who_won", who_won, 2'b01);
        over_ignore();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
